// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Brief    : Run-time controller for a counter-based clock divider. Starts
//             and stops the divided clock and takes new divide ratios over a
//             valid/ready port. Ratio changes and stops only take effect at
//             period boundaries, so div_clk never produces a runt pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_STOP = 2'd2;

    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_MIN_DIV     = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO        = '0;

    logic [1:0]       r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_count,      w_count_nxt;
    logic [CNT_W-1:0] r_cur_div,    w_cur_div_nxt;
    logic [CNT_W-1:0] r_pend_div,   w_pend_div_nxt;
    logic             r_pend_valid, w_pend_valid_nxt;
    logic             r_div_clk,    w_div_clk_nxt;
    logic             r_cfg_err,    w_cfg_err_nxt;

    logic             w_accept;
    logic             w_cfg_bad;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_half;

    // A transfer needs an empty pending slot; ratios below 2 are rejected.
    assign w_accept  = cfg_valid && !r_pend_valid;
    assign w_cfg_bad = (cfg_div < c_MIN_DIV);
    // cur_div is always >= 2, so the subtraction cannot wrap.
    assign w_last    = (r_count == (r_cur_div - c_ONE));
    assign w_cnt_inc = r_count + c_ONE;
    assign w_half    = r_cur_div >> 1;

    // State register and datapath flops, all reset synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_count      <= c_ZERO;
            r_cur_div    <= c_DEFAULT_DIV;
            r_pend_div   <= c_ZERO;
            r_pend_valid <= 1'b0;
            r_div_clk    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_cur_div    <= w_cur_div_nxt;
            r_pend_div   <= w_pend_div_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_div_clk    <= w_div_clk_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    // Next-state logic: div_clk is precomputed for the count/ratio of the
    // upcoming cycle so the output pin comes straight from a flop.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_cur_div_nxt    = r_cur_div;
        w_pend_div_nxt   = r_pend_div;
        w_pend_valid_nxt = r_pend_valid;
        w_div_clk_nxt    = r_div_clk;
        w_cfg_err_nxt    = w_accept && w_cfg_bad;

        case (r_state)
            c_ST_IDLE: begin
                w_count_nxt   = c_ZERO;
                w_div_clk_nxt = 1'b0;
                // A ratio parked while stopping is applied as soon as we idle.
                if (r_pend_valid) begin
                    w_cur_div_nxt    = r_pend_div;
                    w_pend_valid_nxt = 1'b0;
                end
                if (w_accept && !w_cfg_bad) begin
                    w_cur_div_nxt = cfg_div;
                end
                if (en) begin
                    w_state_nxt   = c_ST_RUN;
                    w_div_clk_nxt = 1'b1;
                end
            end

            c_ST_RUN, c_ST_STOP: begin
                if (w_last) begin
                    w_count_nxt = c_ZERO;
                    if (r_pend_valid) begin
                        w_cur_div_nxt    = r_pend_div;
                        w_pend_valid_nxt = 1'b0;
                    end
                    if (en || (r_state == c_ST_RUN)) begin
                        w_state_nxt   = en ? c_ST_RUN : c_ST_STOP;
                        w_div_clk_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = c_ST_IDLE;
                        w_div_clk_nxt = 1'b0;
                    end
                end else begin
                    w_count_nxt   = w_cnt_inc;
                    w_div_clk_nxt = (w_cnt_inc < w_half);
                    w_state_nxt   = en ? c_ST_RUN : c_ST_STOP;
                end
                // Only reachable with the slot empty, so no clash with the
                // boundary update above.
                if (w_accept && !w_cfg_bad) begin
                    w_pend_div_nxt   = cfg_div;
                    w_pend_valid_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_count_nxt   = c_ZERO;
                w_div_clk_nxt = 1'b0;
            end
        endcase
    end

    assign cfg_ready = !r_pend_valid;
    assign cfg_err   = r_cfg_err;
    assign div_clk   = r_div_clk;
    assign tick      = (r_state != c_ST_IDLE) && w_last;
    assign busy      = (r_state != c_ST_IDLE);
    assign cur_div   = r_cur_div;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_ctrl
//  Brief    : Self-checking bench for clk_div_ctrl. A period/position model
//             predicts every output each cycle; directed scenarios are
//             followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 100;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    int checks   = 0;
    int failures = 0;

    // Model: position inside the current output period and ratio in force.
    bit m_busy;
    bit m_stop;
    bit m_err;
    bit m_acc;
    int m_pos;
    int m_n;
    int m_pend[$];

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clk edge using the inputs present at that edge.
    task automatic model_step();
        bit acc;
        bit bnd;
        if (rst) begin
            m_busy = 0; m_stop = 0; m_pos = 0; m_n = DEFAULT_DIV;
            m_err = 0; m_acc = 0; m_pend.delete();
            return;
        end
        acc   = cfg_valid && (m_pend.size() == 0);
        m_acc = acc;
        m_err = acc && (cfg_div < 2);
        if (!m_busy) begin
            if (m_pend.size() != 0) m_n = m_pend.pop_front();
            if (acc && cfg_div >= 2) m_n = int'(cfg_div);
            if (en) begin
                m_busy = 1; m_stop = 0; m_pos = 0;
            end
        end else begin
            bnd = (m_pos == m_n - 1);
            if (bnd) begin
                m_pos = 0;
                if (m_pend.size() != 0) m_n = m_pend.pop_front();
            end else begin
                m_pos++;
            end
            if (acc && cfg_div >= 2) m_pend.push_back(int'(cfg_div));
            if (bnd && m_stop && !en) begin
                m_busy = 0; m_stop = 0; m_pos = 0;
            end else begin
                m_stop = !en;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("div_clk",   32'(div_clk),   32'(m_busy && (m_pos < m_n / 2)));
        chk("tick",      32'(tick),      32'(m_busy && (m_pos == m_n - 1)));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
        chk("cur_div",   32'(cur_div),   32'(m_n));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    task automatic send_cfg(input int v);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(v);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_for(input int n_req, input int pos_req, input int limit, input string tag);
        int k = 0;
        while (!(m_busy && m_n == n_req && m_pos == pos_req)) begin
            if (k >= limit) begin
                checks++; failures++;
                $error("FAIL %s timeout observed=pos%0d expected=pos%0d", tag, m_pos, pos_req);
                return;
            end
            cyc(1);
            k++;
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int k = 0;
        while (m_busy) begin
            if (k >= limit) begin
                checks++; failures++;
                $error("FAIL %s timeout observed=busy expected=idle", tag);
                return;
            end
            cyc(1);
            k++;
        end
    endtask

    int vals[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 13};

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        m_n = DEFAULT_DIV;
        cyc(2);                         // reset values
        rst = 1'b0;

        en = 1'b1;                      // default ratio 100
        cyc(250);
        en = 1'b0;
        wait_idle(200, "stop_n100");

        send_cfg(5);                    // ratio 5 from idle
        en = 1'b1;
        cyc(20);

        send_cfg(10);                   // pending change to 10
        wait_for(10, 3, 60, "reach_n10");
        send_cfg(4);                    // change at count 3
        cyc(20);

        en = 1'b0;                      // ratio 8, stop at count 2
        wait_idle(40, "stop_n4");
        send_cfg(8);
        en = 1'b1;
        wait_for(8, 2, 40, "reach_n8");
        en = 1'b0;
        cyc(1);
        wait_idle(20, "stop_n8");
        en = 1'b1;                      // re-enable during STOPPING
        wait_for(8, 3, 40, "reach_n8b");
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(20);

        send_cfg(1);                    // rejected ratios while running
        cyc(3);
        send_cfg(0);
        cyc(4);
        en = 1'b0;
        wait_idle(20, "stop_err");
        send_cfg(0);                    // rejected ratio in idle
        cyc(3);

        cfg_valid = 1'b1; cfg_div = 16'd3; en = 1'b1;   // en + cfg together
        cyc(1);
        cfg_valid = 1'b0;
        cyc(10);

        en = 1'b0;                      // reset with a config pending
        wait_idle(20, "stop_n3");
        send_cfg(6);
        en = 1'b1;
        wait_for(6, 2, 20, "reach_n6");
        send_cfg(7);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) en = ~en;
            if (!(cfg_valid && !m_acc)) begin
                cfg_valid = ($urandom_range(0, 7) == 0);
                cfg_div   = CNT_W'(vals[$urandom_range(0, 9)]);
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
